keycode_mapper: RTL

KEYCODE_MAPPER -- requirements
Module: keycode_mapper

---
 rtl/keycode_mapper.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/keycode_mapper.sv
// PS/2 scan-code parser that tracks held WASD keys and produces a registered 8-way direction code.
// Optional macro ARROW_KEYS_EN also maps the E0-prefixed arrow keys onto the same flags.
module keycode_mapper #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] scan_code,
  input  logic       code_valid,
  input  logic [1:0] gameState,
  output logic [3:0] keycode,
  output logic       keyPress,
  output logic [3:0] held
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0]  BREAK_PREFIX = 8'hF0;
  localparam logic [7:0]  EXT_PREFIX   = 8'hE0;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic [3:0]  held_reg, held_next;
  logic [3:0]  keycode_reg, keycode_next;
  logic        key_press_reg, key_press_next;

  logic [3:0]  wasd_mask;
  logic        v_up, v_down, h_left, h_right;
  logic [3:0]  direction;
  logic        play;

  // Flag bit order is {up, left, down, right}.
  always_comb begin
    wasd_mask = 4'b0000;
    case (scan_code)
      8'h1D:   wasd_mask = 4'b1000;
      8'h1C:   wasd_mask = 4'b0100;
      8'h1B:   wasd_mask = 4'b0010;
      8'h23:   wasd_mask = 4'b0001;
      default: wasd_mask = 4'b0000;
    endcase
  end

`ifdef ARROW_KEYS_EN
  logic [3:0] arrow_mask;

  always_comb begin
    arrow_mask = 4'b0000;
    case (scan_code)
      8'h75:   arrow_mask = 4'b1000;
      8'h6B:   arrow_mask = 4'b0100;
      8'h72:   arrow_mask = 4'b0010;
      8'h74:   arrow_mask = 4'b0001;
      default: arrow_mask = 4'b0000;
    endcase
  end
`endif

  // A byte arriving on the timeout cycle wins over the timeout.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    held_next  = held_reg;
    if (code_valid) begin
      count_next = 16'd0;
      case (state_reg)
        IDLE: begin
          if (scan_code == BREAK_PREFIX) begin
            state_next = BRK;
          end else if (scan_code == EXT_PREFIX) begin
            state_next = EXT;
          end else begin
            held_next = held_reg | wasd_mask;
          end
        end
        BRK: begin
          if (scan_code != BREAK_PREFIX) begin
            held_next  = held_reg & ~wasd_mask;
            state_next = IDLE;
          end
        end
        EXT: begin
          if (scan_code == BREAK_PREFIX) begin
            state_next = EXT_BRK;
          end else begin
`ifdef ARROW_KEYS_EN
            held_next = held_reg | arrow_mask;
`endif
            state_next = IDLE;
          end
        end
        EXT_BRK: begin
`ifdef ARROW_KEYS_EN
          held_next = held_reg & ~arrow_mask;
`endif
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE) begin
      if (count_reg == TIMEOUT_LAST) begin
        state_next = IDLE;
        count_next = 16'd0;
      end else begin
        count_next = count_reg + 16'd1;
      end
    end
  end

  // Opposing keys on one axis cancel each other.
  assign v_up    = held_next[3] & ~held_next[1];
  assign v_down  = held_next[1] & ~held_next[3];
  assign h_left  = held_next[2] & ~held_next[0];
  assign h_right = held_next[0] & ~held_next[2];
  assign play    = (gameState == 2'b01);

  always_comb begin
    direction = 4'h0;
    case ({v_up, v_down, h_left, h_right})
      4'b0000: direction = 4'h0;
      4'b1000: direction = 4'h1;
      4'b0010: direction = 4'h2;
      4'b0100: direction = 4'h3;
      4'b0001: direction = 4'h4;
      4'b1010: direction = 4'h5;
      4'b1001: direction = 4'h6;
      4'b0110: direction = 4'h7;
      4'b0101: direction = 4'h8;
      default: direction = 4'h0;
    endcase
  end

  always_comb begin
    keycode_next   = play ? direction : 4'h0;
    key_press_next = play & (|held_next);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= IDLE;
      count_reg     <= 16'd0;
      held_reg      <= 4'b0000;
      keycode_reg   <= 4'h0;
      key_press_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      held_reg      <= held_next;
      keycode_reg   <= keycode_next;
      key_press_reg <= key_press_next;
    end
  end

  assign keycode  = keycode_reg;
  assign keyPress = key_press_reg;
  assign held     = held_reg;

endmodule
